// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: shares one DDR AXI4 read port (AR/R) between two requesters.
// Master 0 is the CPU memory path and master 1 is the accelerator data-mover.
// A grant is held from address acceptance until the last read beat completes.
// Optional build macro DDR_RD_ARB_PRIO_EN selects fixed priority (master 0 wins
// every tie). When it is undefined, ties are broken round-robin.
module ddr_rd_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rstn,
  // master 0
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // master 1
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // DDR read port
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  // status
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   pick;
  logic   ar_hs;

  assign ar_hs = s_arvalid & s_arready;

`ifdef DDR_RD_ARB_PRIO_EN
  // Fixed priority: master 1 is chosen only when master 0 is not requesting.
  assign pick = ~m0_arvalid;
`else
  logic last_q, last_d;

  // On a tie grant the master that was not served last; otherwise the lone requester.
  assign pick = (m0_arvalid & m1_arvalid) ? ~last_q : ~m0_arvalid;

  // Remember which master owned the most recently accepted address.
  always_comb begin
    last_d = last_q;
    if (state_q == StAddr && ar_hs) last_d = grant_q;
  end

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  // FSM state and grant registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next state plus all channel routing; everything idles at zero outside the owner's phase.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_arvalid | m1_arvalid) begin
          grant_d = pick;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (grant_q) begin
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end
        if (s_arvalid & s_arready) state_d = StData;
      end
      StData: begin
        if (grant_q) begin
          s_rready  = m1_rready;
          m1_rvalid = s_rvalid;
          if (s_rvalid) begin
            m1_rdata = s_rdata;
            m1_rresp = s_rresp;
            m1_rlast = s_rlast;
          end
        end else begin
          s_rready  = m0_rready;
          m0_rvalid = s_rvalid;
          if (s_rvalid) begin
            m0_rdata = s_rdata;
            m0_rresp = s_rresp;
            m0_rlast = s_rlast;
          end
        end
        // Beats are not counted; the slave's rlast ends the burst.
        if (s_rvalid & s_rready & s_rlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Two-requester AXI4 read-channel arbiter in front of the single DDR read port of `system`. It shares the DDR AR/R channels between the CPU memory path (master 0) and the Versat accelerator data-mover (master 1). A grant is held from address acceptance until the last read beat of the burst completes. Write channels bypass this block.

## Interface
- `ADDR_W`, default 30: AXI address width (`DDR_ADDR_W`).
- `DATA_W`, default 256: AXI read data width (`MIG_BUS_W`).
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- `m0_araddr`, `m1_araddr` in `ADDR_W`: requester read address.
- `m0_arlen`, `m1_arlen` in 8: requester burst length minus 1.
- `m0_arvalid`, `m1_arvalid` in 1: requester address valid.
- `m0_arready`, `m1_arready` out 1: address accepted.
- `m0_rdata`, `m1_rdata` out `DATA_W`: read data.
- `m0_rresp`, `m1_rresp` out 2: read response.
- `m0_rlast`, `m1_rlast` out 1: last beat.
- `m0_rvalid`, `m1_rvalid` out 1: beat valid.
- `m0_rready`, `m1_rready` in 1: requester accepts beat.
- `s_araddr` out `ADDR_W`, `s_arlen` out 8, `s_arvalid` out 1, `s_arready` in 1: DDR AR channel.
- `s_rdata` in `DATA_W`, `s_rresp` in 2, `s_rlast` in 1, `s_rvalid` in 1, `s_rready` out 1: DDR R channel.
- `grant` out 1: index of the owning master. Valid when `busy` is high.
- `busy` out 1: high in ADDR and DATA.

## Operation
- FSM has three states: IDLE, ADDR, DATA. Reset puts it in IDLE.
- IDLE:
  - If any `mX_arvalid` is high, register `grant` and go to ADDR.
  - If only one is requesting, grant it.
  - If both are requesting, grant the master not equal to `last`.
  - `last` resets to 1, so master 0 wins the first tie.
- ADDR:
  - `s_araddr`/`s_arlen`/`s_arvalid` are driven combinationally from the granted master.
  - The granted master's `arready` equals `s_arready`.
  - On `s_arvalid & s_arready`, set `last <= grant` and go to DATA.
- DATA:
  - `s_r*` are routed to the granted master and `s_rready` equals its `rready`.
  - On `s_rvalid & s_rready & s_rlast`, return to IDLE.
- The non-granted master, and both masters outside their active state, see `arready=0` and `rvalid=0`. `rdata`, `rresp` and `rlast` are zero whenever the matching `rvalid` is 0.
- In IDLE, `s_arvalid=0` and `s_rready=0`.
- One outstanding burst at a time. `s_arlen` passes through unmodified; the block does not count beats and relies on `s_rlast`.
- Requesters must hold `arvalid`/`araddr`/`arlen` stable until `arready`, per AXI. The block does not check this.

## Timing
- Reset values:
  - FSM in IDLE, `grant=0`, `busy=0`, `last=1`.
  - All `arready`/`rvalid`/`rlast`/`s_arvalid`/`s_rready` low; all data outputs zero.
- Latency: `mX_arvalid` rising in IDLE at cycle 0 gives `s_arvalid` high at cycle 1. Grant is not combinational.
- The R path is purely combinational: zero added latency per beat. Backpressure passes through unchanged.
- The `rlast` handshake at cycle N returns the FSM to IDLE at N+1. A pending request is granted at N+1 and `s_arvalid` rises at N+2, so the minimum bubble between bursts is 2 cycles.
- `s_rlast` with `rready` low: stay in DATA until the handshake.
- A single-beat burst (`arlen=0`) works; DATA lasts until the first beat handshake.
- A request arriving on the other master during ADDR/DATA waits; it is considered only in IDLE.
- Asserting `rstn` low mid-burst aborts immediately to IDLE with all outputs at reset values. The DDR model/controller shares `rstn`.

## Configuration
- `DDR_RD_ARB_PRIO_EN`:
  - Defined: fixed priority. Master 0 always wins a tie in IDLE and `last` is unused. Master 1 can starve; this mode is for latency-critical CPU fetch.
  - Undefined: round-robin as described under Operation.

## Test plan
- Single requester: m0 requests `araddr=0x100`, `arlen=3`, with slave `arready` immediate.
  - `s_arvalid` rises 1 cycle after `m0_arvalid`.
  - 4 beats reach m0 with `m0_rlast` on the 4th.
  - `m1_rvalid` stays 0.
  - `busy` falls the cycle after the last beat.
- Simultaneous requests after reset (both `arvalid` in the same cycle, `arlen=1`):
  - Round-robin: m0 is served first, then m1 with `s_arvalid` rising 2 cycles after m0's `rlast` handshake.
  - Keep both requesting for a third burst: the grant sequence is 0, 1, 0.
- Priority build (`DDR_RD_ARB_PRIO_EN`) with both masters continuously requesting: the grant sequence is 0, 0, 0 and m1 is never granted.
- Backpressure: m1 `rready` toggles 1/0 during an `arlen=7` burst.
  - Exactly 8 handshakes are delivered.
  - `s_rready` mirrors `m1_rready` every cycle.
  - The FSM stays in DATA while `s_rlast` is held with `rready=0`.
- Slave AR stall: `s_arready` is held low 5 cycles.
  - `m0_arready` stays 0 and `s_araddr` stays stable.
  - A late m1 request does not change `grant`.
- Reset mid-burst: drop `rstn` after beat 2 of 4.
  - All outputs return to reset values asynchronously.
  - After release, a new m1 request is granted normally.
